// File: rtl/pipelined_alu_md.sv
// rtl/pipelined_alu_md.sv - registered EX-stage ALU with iterative multiply/divide and HI/LO
//
// Ports:
//   Clk       in   clock, all state updates on the rising edge
//   Reset     in   synchronous active-high reset
//   InValid   in   operation present on BusA/BusB/ALUCtrl
//   InReady   out  combinational accept (low during reset or for MD ops while Busy)
//   ALUCtrl   in   5-bit opcode; 0x00-0x0E ALU, 0x10-0x17 multiply/divide class
//   BusA/BusB in   operands; BusA[SHW-1:0] is the shift amount
//   BusW      out  registered result
//   Zero      out  registered BusW == 0
//   Overflow  out  registered signed overflow (ADD/SUB only)
//   OutValid  out  registered, high for the cycle BusW holds a writeback result
//   Busy      out  multiply/divide in progress
module pipelined_alu_md #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [4:0]       ALUCtrl,
    input  logic [WIDTH-1:0] BusA,
    input  logic [WIDTH-1:0] BusB,
    output logic [WIDTH-1:0] BusW,
    output logic             Zero,
    output logic             Overflow,
    output logic             OutValid,
    output logic             Busy
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [4:0] OP_AND  = 5'h00, OP_OR   = 5'h01, OP_ADD  = 5'h02, OP_SLL  = 5'h03;
    localparam logic [4:0] OP_SRL  = 5'h04, OP_SUB  = 5'h06, OP_SLT  = 5'h07, OP_ADDU = 5'h08;
    localparam logic [4:0] OP_SUBU = 5'h09, OP_XOR  = 5'h0A, OP_SLTU = 5'h0B, OP_NOR  = 5'h0C;
    localparam logic [4:0] OP_SRA  = 5'h0D, OP_LUI  = 5'h0E;
    localparam logic [4:0] OP_MULT = 5'h10, OP_MULTU = 5'h11, OP_DIV = 5'h12, OP_DIVU = 5'h13;
    localparam logic [4:0] OP_MFHI = 5'h14, OP_MFLO = 5'h15, OP_MTHI = 5'h16, OP_MTLO = 5'h17;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} md_state_e;

    md_state_e state_q, state_d;

    logic [WIDTH-1:0] busw_q, hi_q, lo_q;
    logic             zero_q, ovf_q, outvalid_q;

    // Iterative unit: rem_q is the upper accumulator / partial remainder,
    // quo_q the multiplier / dividend that turns into LO / quotient,
    // dvs_q the multiplicand / divisor.
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [CW-1:0]    cnt_q;
    logic             is_div_q, neg_q, rneg_q, dz_q;

    logic             md_class, accept, md_start;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sum_add, diff_sub;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf, alu_wb;

    assign md_class = (ALUCtrl[4:3] == 2'b10);
    assign InReady  = ~Reset & ~(Busy & md_class);
    assign accept   = InValid & InReady;
    assign md_start = accept & (ALUCtrl[4:2] == 3'b100);
    assign shamt    = BusA[SHW-1:0];
    assign sum_add  = BusA + BusB;
    assign diff_sub = BusA - BusB;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_wb  = 1'b1;
        case (ALUCtrl)
            OP_AND:  alu_res = BusA & BusB;
            OP_OR:   alu_res = BusA | BusB;
            OP_ADD: begin
                alu_res = sum_add;
                alu_ovf = (BusA[WIDTH-1] == BusB[WIDTH-1]) && (sum_add[WIDTH-1] != BusA[WIDTH-1]);
            end
            OP_SLL:  alu_res = BusB << shamt;
            OP_SRL:  alu_res = BusB >> shamt;
            OP_SUB: begin
                alu_res = diff_sub;
                alu_ovf = (BusA[WIDTH-1] != BusB[WIDTH-1]) && (diff_sub[WIDTH-1] != BusA[WIDTH-1]);
            end
            OP_SLT:  alu_res = WIDTH'($signed(BusA) < $signed(BusB));
            OP_ADDU: alu_res = sum_add;
            OP_SUBU: alu_res = diff_sub;
            OP_XOR:  alu_res = BusA ^ BusB;
            OP_SLTU: alu_res = WIDTH'(BusA < BusB);
            OP_NOR:  alu_res = ~(BusA | BusB);
            OP_SRA:  alu_res = $signed(BusB) >>> shamt;
            OP_LUI:  alu_res = BusB << (WIDTH / 2);
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO: alu_wb = 1'b0;
            default: alu_res = '0;
        endcase
    end

    // Result register; BusW/Zero/Overflow hold when nothing is written back.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            busw_q     <= '0;
            zero_q     <= 1'b1;
            ovf_q      <= 1'b0;
            outvalid_q <= 1'b0;
        end else begin
            outvalid_q <= accept & alu_wb;
            if (accept && alu_wb) begin
                busw_q <= alu_res;
                zero_q <= (alu_res == '0);
                ovf_q  <= alu_ovf;
            end
        end
    end

    assign BusW     = busw_q;
    assign Zero     = zero_q;
    assign Overflow = ovf_q;
    assign OutValid = outvalid_q;

    // MD FSM: state register
    always_ff @(posedge Clk) begin
        if (Reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // MD FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (md_start) state_d = S_RUN;
            S_RUN:   if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // MD FSM: outputs
    always_comb begin
        Busy = (state_q != S_IDLE);
    end

    logic             op_signed;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   mul_sum, mul_acc, div_shift;
    logic [WIDTH-1:0] div_trial;
    logic             div_ge;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    always_comb begin
        op_signed = ~ALUCtrl[0];
        a_abs     = (op_signed && BusA[WIDTH-1]) ? -BusA : BusA;
        b_abs     = (op_signed && BusB[WIDTH-1]) ? -BusB : BusB;

        // shift-add step: conditionally add multiplicand, then shift {acc,multiplier} right
        mul_sum   = {1'b0, rem_q} + {1'b0, dvs_q};
        mul_acc   = quo_q[0] ? mul_sum : {1'b0, rem_q};

        // restoring step: bring in next dividend bit, subtract if it fits
        div_shift = {rem_q, quo_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, dvs_q});
        div_trial = div_shift[WIDTH-1:0] - dvs_q;

        prod      = {rem_q, quo_q};
        prod_fix  = neg_q ? -prod : prod;
        quo_fix   = dz_q ? '1 : (neg_q ? -quo_q : quo_q);
        rem_fix   = rneg_q ? -rem_q : rem_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            hi_q     <= '0;
            lo_q     <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (md_start) begin
                        is_div_q <= ALUCtrl[1];
                        rem_q    <= '0;
                        cnt_q    <= '0;
                        neg_q    <= op_signed & (BusA[WIDTH-1] ^ BusB[WIDTH-1]);
                        rneg_q   <= op_signed & BusA[WIDTH-1];
                        dz_q     <= ALUCtrl[1] & (BusB == '0);
                        if (ALUCtrl[1]) begin
                            quo_q <= a_abs;
                            dvs_q <= b_abs;
                        end else begin
                            quo_q <= b_abs;
                            dvs_q <= a_abs;
                        end
                    end else if (accept && ALUCtrl == OP_MTHI) begin
                        hi_q <= BusA;
                    end else if (accept && ALUCtrl == OP_MTLO) begin
                        lo_q <= BusA;
                    end
                end
                S_RUN: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (is_div_q) begin
                        rem_q <= div_ge ? div_trial : div_shift[WIDTH-1:0];
                        quo_q <= {quo_q[WIDTH-2:0], div_ge};
                    end else begin
                        rem_q <= mul_acc[WIDTH:1];
                        quo_q <= {mul_acc[0], quo_q[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    if (is_div_q) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipelined_alu_md.sv
// tb/tb_pipelined_alu_md.sv - scoreboard bench for pipelined_alu_md (WIDTH=32 and WIDTH=8)
module tb_pipelined_alu_md;

    typedef struct {
        logic [31:0] w;
        logic        o;
        string       nm;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Reset;

    logic        InValid, InReady, Zero, Overflow, OutValid, Busy;
    logic [4:0]  ALUCtrl;
    logic [31:0] BusA, BusB, BusW;

    logic        v8, rdy8, z8, ov8, oval8, busy8;
    logic [4:0]  op8;
    logic [7:0]  a8, b8, w8;

    exp_t q32[$];
    exp_t q8[$];

    int errors = 0;
    int checks = 0;
    int st;

    always #5 Clk = ~Clk;

    pipelined_alu_md #(.WIDTH(32)) dut32 (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady), .ALUCtrl(ALUCtrl),
        .BusA(BusA), .BusB(BusB), .BusW(BusW), .Zero(Zero), .Overflow(Overflow),
        .OutValid(OutValid), .Busy(Busy)
    );

    pipelined_alu_md #(.WIDTH(8)) dut8 (
        .Clk(Clk), .Reset(Reset), .InValid(v8), .InReady(rdy8), .ALUCtrl(op8),
        .BusA(a8), .BusB(b8), .BusW(w8), .Zero(z8), .Overflow(ov8),
        .OutValid(oval8), .Busy(busy8)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitors: pop and compare whenever a result is presented.
    always @(negedge Clk) begin
        if (!Reset && OutValid) begin
            if (q32.size() == 0) begin
                chk("w32_unexpected_outvalid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q32.pop_front();
                chk({e.nm, "_busw"}, BusW, e.w);
                chk({e.nm, "_zero"}, Zero, e.w == 32'd0);
                chk({e.nm, "_ovf"}, Overflow, e.o);
            end
        end
    end

    always @(negedge Clk) begin
        if (!Reset && oval8) begin
            if (q8.size() == 0) begin
                chk("w8_unexpected_outvalid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk({e.nm, "_busw"}, w8, e.w[7:0]);
                chk({e.nm, "_zero"}, z8, e.w[7:0] == 8'd0);
            end
        end
    end

    // Present an op and hold it until accepted; returns with inputs still driven, 1ns after the accepting edge.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic wb, input logic [31:0] ew, input logic eo,
                         input string nm, output int stalls);
        bit done = 0;
        InValid = 1'b1; ALUCtrl = op; BusA = a; BusB = b;
        stalls = 0;
        while (!done) begin
            @(negedge Clk);
            if (InReady) begin
                @(posedge Clk); #1;
                done = 1;
                if (wb) q32.push_back('{w: ew, o: eo, nm: nm});
            end else begin
                stalls++;
                @(posedge Clk); #1;
                if (stalls > 200) begin
                    chk({nm, "_accept_timeout"}, 64'd0, 64'd1);
                    done = 1;
                end
            end
        end
    endtask

    task automatic issue8(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic wb, input logic [7:0] ew, input string nm, output int stalls);
        bit done = 0;
        v8 = 1'b1; op8 = op; a8 = a; b8 = b;
        stalls = 0;
        while (!done) begin
            @(negedge Clk);
            if (rdy8) begin
                @(posedge Clk); #1;
                done = 1;
                if (wb) q8.push_back('{w: {24'd0, ew}, o: 1'b0, nm: nm});
            end else begin
                stalls++;
                @(posedge Clk); #1;
                if (stalls > 200) begin
                    chk({nm, "_accept_timeout"}, 64'd0, 64'd1);
                    done = 1;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        InValid = 1'b0; v8 = 1'b0;
        repeat (n) begin
            @(posedge Clk); #1;
        end
    endtask

    initial begin
        Reset = 1'b1; InValid = 1'b0; ALUCtrl = '0; BusA = '0; BusB = '0;
        v8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;

        // power-on reset values
        @(posedge Clk); #1;
        @(negedge Clk);
        chk("rst_inready", InReady, 0);
        chk("rst_busw", BusW, 0);
        chk("rst_zero", Zero, 1);
        chk("rst_ovf", Overflow, 0);
        chk("rst_outvalid", OutValid, 0);
        chk("rst_busy", Busy, 0);
        @(posedge Clk); #1;
        Reset = 1'b0;

        // reset held 2 cycles in the middle of a DIV
        issue(5'h02, 32'd5, 32'd6, 1, 32'd11, 0, "pre_add", st);
        issue(5'h12, 32'd100, 32'd7, 0, 0, 0, "div_abort", st);
        idle(5);
        chk("div_busy_before_reset", Busy, 1);
        Reset = 1'b1;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(negedge Clk);
        chk("abort_busw", BusW, 0);
        chk("abort_zero", Zero, 1);
        chk("abort_ovf", Overflow, 0);
        chk("abort_outvalid", OutValid, 0);
        chk("abort_busy", Busy, 0);
        chk("abort_inready", InReady, 1);
        @(posedge Clk); #1;
        issue(5'h14, 0, 0, 1, 32'd0, 0, "abort_mfhi", st);
        issue(5'h15, 0, 0, 1, 32'd0, 0, "abort_mflo", st);

        // back-to-back ALU ops
        issue(5'h02, 32'h7FFF_FFFF, 32'd1, 1, 32'h8000_0000, 1, "add_ovf", st);
        issue(5'h08, 32'h7FFF_FFFF, 32'd1, 1, 32'h8000_0000, 0, "addu", st);
        issue(5'h0D, 32'd36, 32'h8000_0000, 1, 32'hF800_0000, 0, "sra", st);
        issue(5'h06, 32'h8000_0000, 32'd1, 1, 32'h7FFF_FFFF, 1, "sub_ovf", st);
        issue(5'h09, 32'h8000_0000, 32'd1, 1, 32'h7FFF_FFFF, 0, "subu", st);
        issue(5'h07, 32'hFFFF_FFFF, 32'd1, 1, 32'd1, 0, "slt", st);
        issue(5'h0B, 32'hFFFF_FFFF, 32'd1, 1, 32'd0, 0, "sltu", st);
        issue(5'h0E, 32'd0, 32'h0000_1234, 1, 32'h1234_0000, 0, "lui", st);
        issue(5'h0C, 32'h0F0F_0000, 32'h0000_00FF, 1, 32'hF0F0_FF00, 0, "nor", st);
        issue(5'h03, 32'd4, 32'h0000_0001, 1, 32'h0000_0010, 0, "sll", st);
        issue(5'h04, 32'd4, 32'h8000_0000, 1, 32'h0800_0000, 0, "srl", st);
        issue(5'h0A, 32'hFF00_FF00, 32'h0FF0_0FF0, 1, 32'hF0F0_F0F0, 0, "xor", st);
        issue(5'h05, 32'd3, 32'd4, 1, 32'd0, 0, "undef_op", st);
        idle(2);

        // MULT -3 x 7 with immediate MFLO
        issue(5'h10, 32'hFFFF_FFFD, 32'd7, 0, 0, 0, "mult", st);
        issue(5'h15, 0, 0, 1, 32'hFFFF_FFEB, 0, "mult_mflo", st);
        chk("mult_stall_cycles", st, 33);
        issue(5'h14, 0, 0, 1, 32'hFFFF_FFFF, 0, "mult_mfhi", st);

        // DIV -7 / 2 with an ADD slipped in while Busy
        issue(5'h12, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, "div", st);
        issue(5'h02, 32'd2, 32'd3, 1, 32'd5, 0, "add_during_busy", st);
        chk("add_during_busy_stalls", st, 0);
        issue(5'h15, 0, 0, 1, 32'hFFFF_FFFD, 0, "div_mflo", st);
        chk("div_mflo_stalls", st, 32);
        issue(5'h14, 0, 0, 1, 32'hFFFF_FFFF, 0, "div_mfhi", st);

        // DIVU 5 / 0
        issue(5'h13, 32'd5, 32'd0, 0, 0, 0, "divu0", st);
        issue(5'h15, 0, 0, 1, 32'hFFFF_FFFF, 0, "divu0_mflo", st);
        issue(5'h14, 0, 0, 1, 32'd5, 0, "divu0_mfhi", st);

        // DIV MIN / -1
        issue(5'h12, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, "divmin", st);
        issue(5'h15, 0, 0, 1, 32'h8000_0000, 0, "divmin_mflo", st);
        issue(5'h14, 0, 0, 1, 32'd0, 0, "divmin_mfhi", st);

        // MTLO then MFLO next cycle
        issue(5'h17, 32'hCAFE_F00D, 0, 0, 0, 0, "mtlo", st);
        issue(5'h15, 0, 0, 1, 32'hCAFE_F00D, 0, "mtlo_mflo", st);
        idle(2);

        // WIDTH=8 instance
        issue8(5'h11, 8'hFF, 8'hFF, 0, 0, "w8_multu", st);
        issue8(5'h14, 0, 0, 1, 8'hFE, "w8_multu_mfhi", st);
        chk("w8_multu_stalls", st, 9);
        issue8(5'h15, 0, 0, 1, 8'h01, "w8_multu_mflo", st);
        issue8(5'h16, 8'h5A, 0, 0, 0, "w8_mthi", st);
        issue8(5'h14, 0, 0, 1, 8'h5A, "w8_mthi_mfhi", st);
        issue8(5'h13, 8'd100, 8'd7, 0, 0, "w8_divu", st);
        issue8(5'h15, 0, 0, 1, 8'h0E, "w8_divu_mflo", st);
        issue8(5'h14, 0, 0, 1, 8'h02, "w8_divu_mfhi", st);
        issue8(5'h02, 8'h7F, 8'h01, 1, 8'h80, "w8_add", st);
        idle(3);

        chk("w32_scoreboard_drained", q32.size(), 0);
        chk("w8_scoreboard_drained", q8.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
